// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard port.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FILTER_LEN = 3;

  // Bus decoder matches address bits [15:8] against this value (0xffff_01xx).
  localparam logic [15:0] KBD_ADDR_DECODE = 16'h0100;
  localparam logic [15:0] KBD_ADDR_MASK   = 16'hff00;

  // Odd parity holds when the data bits and parity bit together contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head byte reads as zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // When full, a same-cycle pop frees the slot the push is about to fill.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard receiver: pin sync/filter, frame FSM with timeout, scan-code FIFO.
// Build option PS2_PARITY_CHECK_EN enables odd-parity rejection and kbd_parity_err.
module ps2_kbd_port
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  input  logic       clr_flags,
  output logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       kbd_overflow,
  output logic       kbd_parity_err
);

  localparam int unsigned CntW = $clog2(PS2_DATA_BITS);
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [1:0]                clk_sync_q, data_sync_q;
  logic [PS2_FILTER_LEN-1:0] hist_q;
  logic                      filt_q, filt_d, fall_q;
  logic                      data_bit;

  ps2_state_e                state_q;
  logic [CntW-1:0]           bit_cnt_q;
  logic [PS2_DATA_BITS-1:0]  shreg_q;
  logic [TmoW-1:0]           tmo_q;
  logic                      ovf_q, perr_q;
  logic                      frame_good, push, ovf_set, perr_set, timed_out;
  logic                      fifo_full, fifo_empty;
`ifdef PS2_PARITY_CHECK_EN
  logic                      parity_q;
`endif

  // Synchronizers and filter preset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      hist_q      <= '1;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      hist_q      <= {hist_q[PS2_FILTER_LEN-2:0], clk_sync_q[1]};
      filt_q      <= filt_d;
      fall_q      <= filt_q & ~filt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    if (hist_q == '0)     filt_d = 1'b0;
    else if (&hist_q)     filt_d = 1'b1;
  end

  assign data_bit = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  assign frame_good = odd_parity_ok(shreg_q, parity_q);
  assign perr_set   = fall_q && (state_q == StStop) && data_bit && !frame_good;
`else
  assign frame_good = 1'b1;
  assign perr_set   = 1'b0;
`endif

  assign push      = fall_q && (state_q == StStop) && data_bit && frame_good;
  assign ovf_set   = push & fifo_full & ~rd_en;
  assign timed_out = (state_q != StIdle) && !fall_q && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      // Set events take priority over a simultaneous clear.
      if (ovf_set)        ovf_q <= 1'b1;
      else if (clr_flags) ovf_q <= 1'b0;
      if (perr_set)       perr_q <= 1'b1;
      else if (clr_flags) perr_q <= 1'b0;

      if (state_q == StIdle || fall_q) tmo_q <= '0;
      else                             tmo_q <= tmo_q + TmoW'(1);

      if (timed_out) begin
        state_q <= StIdle;
      end else if (fall_q) begin
        unique case (state_q)
          StIdle: begin
            if (!data_bit) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shreg_q <= {data_bit, shreg_q[PS2_DATA_BITS-1:1]};
            if (bit_cnt_q == CntW'(PS2_DATA_BITS - 1)) state_q <= StParity;
            else                                       bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
          StParity: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= data_bit;
`endif
            state_q  <= StStop;
          end
          StStop: state_q <= StIdle;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shreg_q),
    .pop   (rd_en),
    .rdata (kbd_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign kbd_ready      = ~fifo_empty;
  assign kbd_overflow   = ovf_q;
  assign kbd_parity_err = perr_q;

endmodule

// File: doc/ps2_kbd_port.md
# ps2_kbd_port

Bus-side PS/2 keyboard responder for the MIPS SoC. It receives device-to-host PS/2 frames on the ps2_clk/ps2_data pins, checks each frame, and queues the scan-code bytes in a small FIFO. The memory-I/O bus reads the head byte at the keyboard address 0xffff_01xx, and that read pops the byte.

## Interface
- FIFO_DEPTH, 8, number of queued scan codes; must be a power of 2 and at least 2
- TIMEOUT_CYC, 50000, number of clk cycles without a PS/2 falling edge before a partial frame is aborted

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous to clk
- ps2_data  in  1  raw PS/2 data pin; asynchronous to clk
- rd_en  in  1  one-cycle pop strobe from the bus decoder (CPU read of 0xffff_01xx with mem_w=0)
- clr_flags  in  1  one-cycle pulse that clears the sticky flags
- kbd_data  out  8  head FIFO byte; 8'h00 when the FIFO is empty
- kbd_ready  out  1  FIFO not empty
- kbd_overflow  out  1  sticky; a good frame arrived while the FIFO was full
- kbd_parity_err  out  1  sticky; a frame failed the odd-parity check

## Operation
- Input conditioning:
  - Both pins pass through a 2-FF synchronizer.
  - ps2_clk is then filtered: the filtered value changes only after 3 consecutive synchronized samples agree.
  - A falling edge of the filtered clock produces a one-cycle fall pulse. ps2_data is sampled on that pulse.
- Frame FSM (11-bit frame: start, 8 data bits LSB first, parity, stop):
  - IDLE: on fall, if data=0 go to DATA with bit count 0; if data=1 stay in IDLE.
  - DATA: on fall, shift the bit into shreg[7] (right shift). After the 8th bit go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, if data=1 and parity is good, push shreg. A bad stop bit discards the frame silently. Return to IDLE either way.
- Odd parity: XOR of the 8 data bits and the parity bit must equal 1.
- Timeout: in any state other than IDLE, a counter runs and resets on every fall pulse. When it reaches TIMEOUT_CYC-1, the FSM returns to IDLE, the partial frame is discarded and no flag is set.
- FIFO:
  - Push when full: the byte is dropped and kbd_overflow is set.
  - Push and pop in the same cycle while full: the pop is applied first, the push is accepted, and no overflow is flagged.
  - rd_en while empty: ignored.
  - The pointers carry one extra wrap bit for full/empty detection.
- Sticky flags: set events win over a simultaneous clr_flags.
- Reset:
  - Outputs: kbd_data=8'h00, kbd_ready=0, kbd_overflow=0, kbd_parity_err=0.
  - Internal: FSM in IDLE, FIFO emptied, synchronizers and filter preset to 1 (idle bus level).
  - Reset mid-frame abandons the frame. Nothing is pushed.

## Timing
- Pin-to-edge latency: the fall pulse is asserted 5 cycles after the first clk edge that samples ps2_clk low (2 synchronizer + 3 filter stages).
- Push latency: the push occurs on the cycle of the STOP fall pulse. kbd_ready and kbd_data are valid on the next cycle.
- Pop latency: after rd_en is sampled, kbd_data shows the next entry (or 8'h00) and kbd_ready updates on the following cycle.
- rd_en held high for N cycles pops N entries. The bus decoder guarantees a single-cycle strobe.

## Configuration
- PS2_PARITY_CHECK_EN defined: a bad-parity frame is discarded and sets kbd_parity_err.
- PS2_PARITY_CHECK_EN undefined: the parity bit is shifted in but ignored, every frame with a good stop bit is pushed, and kbd_parity_err is tied to 0.

## Structure
- Shared package ps2_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP)
  - PS2_DATA_BITS = 8
  - PS2_FILTER_LEN = 3
  - the keyboard address constant 16'h01xx decode value
- Sub-module sync_fifo (parameters WIDTH, DEPTH) implements the queue. The synchronizer, filter and FSM live in ps2_kbd_port.

## Test plan
- Reset mid-frame: send start + 4 bits, assert rst for 1 cycle, finish the bits → nothing pushed; kbd_ready=0, kbd_data=8'h00.
- Single frame: send 0x1C with parity 0 and stop 1 → kbd_ready=1 and kbd_data=8'h1C one cycle after the STOP fall pulse; one rd_en → kbd_ready=0, kbd_data=8'h00.
- Parity error: send 0x1C with parity 1, with PS2_PARITY_CHECK_EN defined → no push, kbd_parity_err=1; clr_flags → kbd_parity_err=0.
- Overflow: send 9 frames 0x01..0x09 with depth 8 and no reads → kbd_overflow=1; 8 pops return 0x01..0x08 in order.
- Full FIFO with push and pop in the same cycle: fill the FIFO, then align rd_en with the STOP fall of frame 0x55 → no overflow, and 0x55 is the last of 8 entries.
- Timeout and glitch: stall ps2_clk for TIMEOUT_CYC cycles after 3 bits, then send a clean 0xF0 → only 0xF0 is queued; a 2-cycle ps2_clk low glitch in IDLE → no state change.
